// File: rtl/lut_bank_seq.sv
// lut_bank_seq: run-time loadable 2^N_IN x N_OUT truth table.
// Rows are loaded serially, read back by single lookups through a
// valid/ready handshake, or streamed out in index order by a sweep.
module lut_bank_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_pos,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             sweep_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_vec,
  output logic [N_IN-1:0]  out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             loaded
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP} state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  wptr_q, wptr_d;
  logic [N_IN-1:0]  sptr_q, sptr_d;
  logic             pos_q, pos_d;
  logic             loaded_q, loaded_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_vec_q, out_vec_d;
  logic [N_IN-1:0]  out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic [N_OUT-1:0] tbl_q [DEPTH];
  logic             free;
  logic             wr_en;
  logic [N_OUT-1:0] wr_data;

  // The output slot can take a new result when empty or being consumed now.
  assign free      = !out_valid_q || out_ready;
  assign cfg_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign loaded    = loaded_q;
  // Product-of-sums rows are stored inverted so lookups always return the function value.
  assign wr_data   = pos_q ? ~cfg_data : cfg_data;

  // Next-state, pointer, table-write and output-slot decisions.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    sptr_d      = sptr_q;
    pos_d       = pos_q;
    loaded_d    = loaded_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    in_ready    = (state_q == S_IDLE) && free && !cfg_start && !sweep_start;
    // A free slot empties unless something is issued below.
    if (free) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          pos_d   = cfg_pos;
        end else if (sweep_start && free) begin
          state_d = S_SWEEP;
          sptr_d  = '0;
        end else if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
          out_vec_d   = tbl_q[in_vec];
          out_idx_d   = in_vec;
          out_last_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == LAST_ROW) begin
            state_d  = S_IDLE;
            loaded_d = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        // Pointer only advances when a row is actually issued, so a stalled
        // consumer never causes a skipped or repeated row.
        if (free) begin
          out_valid_d = 1'b1;
          out_vec_d   = tbl_q[sptr_q];
          out_idx_d   = sptr_q;
          out_last_d  = (sptr_q == LAST_ROW);
          sptr_d      = sptr_q + 1'b1;
          if (sptr_q == LAST_ROW) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      sptr_q      <= '0;
      pos_q       <= 1'b0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      sptr_q      <= sptr_d;
      pos_q       <= pos_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Truth-table storage; reset clears every row so unloaded lookups read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_lut_bank_seq.sv
// Bench for lut_bank_seq: directed sequence with randomized data, checked
// against a plain array model of the truth table.
module tb_lut_bank_seq;

  localparam int N_IN  = 4;
  localparam int N_OUT = 10;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic             cfg_pos = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [N_OUT-1:0] cfg_data = '0;
  logic             sweep_start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N_OUT-1:0] out_vec;
  logic [N_IN-1:0]  out_idx;
  logic             out_last;
  logic             busy;
  logic             loaded;

  lut_bank_seq #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_pos(cfg_pos), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .sweep_start(sweep_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .loaded(loaded)
  );

  always #5 clk = ~clk;

  // Reference model: the function table as the user intends it.
  logic [N_OUT-1:0] m_tbl [DEPTH];
  logic             m_loaded;
  logic             m_pos;
  int               m_wp;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    m_loaded = 1'b0;
    m_wp = 0;
  endtask

  task automatic lookup(input logic [N_IN-1:0] v);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'b1;
    #1;
    chk("lk_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("lk_valid", 32'(out_valid), 32'd1);
    chk("lk_vec", 32'(out_vec), 32'(m_tbl[v]));
    chk("lk_idx", 32'(out_idx), 32'(v));
    chk("lk_last", 32'(out_last), 32'd0);
  endtask

  task automatic start_load(input logic pos);
    cfg_start = 1'b1;
    cfg_pos   = pos;
    m_pos     = pos;
    step();
    cfg_start = 1'b0;
    m_wp      = 0;
    chk("ld_busy", 32'(busy), 32'd1);
    chk("ld_cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  // mode 0: row = 3FF^i, mode 1: row = 1<<(i%10), mode 2: random rows with gaps and noise.
  task automatic feed_rows(input int mode, input int n);
    logic [N_OUT-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (mode == 2 && $urandom_range(0, 2) == 0) begin
        cfg_valid   = 1'b0;
        sweep_start = 1'($urandom);
        in_valid    = 1'b1;
        in_vec      = 4'($urandom);
        #1;
        chk("ld_gap_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("ld_gap_cfg_ready", 32'(cfg_ready), 32'd1);
        sweep_start = 1'b0;
        in_valid    = 1'b0;
      end
      case (mode)
        0:       d = 10'h3FF ^ 10'(i);
        1:       d = 10'h001 << (i % 10);
        default: d = 10'($urandom);
      endcase
      cfg_valid = 1'b1;
      cfg_data  = d;
      step();
      cfg_valid = 1'b0;
      m_tbl[m_wp] = m_pos ? ~d : d;
      m_wp++;
      if (m_wp == DEPTH) m_loaded = 1'b1;
      chk("ld_loaded", 32'(loaded), 32'(m_loaded));
      chk("ld_busy_row", 32'(busy), 32'(m_wp != DEPTH));
    end
  endtask

  initial begin
    int cnt;
    logic r;
    model_reset();

    // Reset state
    #23;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    rst_n = 1'b1;
    step();

    // Lookup before any load returns zero rows
    lookup(4'h5);
    chk("pre_loaded", 32'(loaded), 32'd0);
    step();
    chk("idle_drain", 32'(out_valid), 32'd0);

    // Sum-of-products load, no gaps
    start_load(1'b0);
    feed_rows(0, DEPTH);
    lookup(4'hA);
    chk("sop_A", 32'(out_vec), 32'h3F5);

    // Product-of-sums reload while loaded
    start_load(1'b1);
    chk("reload_loaded", 32'(loaded), 32'd1);
    feed_rows(1, DEPTH);
    lookup(4'h3);
    chk("pos_3", 32'(out_vec), 32'h3F7);
    lookup(4'hC);
    chk("pos_C", 32'(out_vec), 32'h3FB);

    // Random back-to-back lookups
    for (int i = 0; i < 20; i++) lookup(4'($urandom));
    step();
    chk("lk_drain", 32'(out_valid), 32'd0);

    // Sweep with out_ready toggling 1,0,1,0
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("sw_busy", 32'(busy), 32'd1);
    chk("sw_first_empty", 32'(out_valid), 32'd0);
    cnt = 0;
    for (int k = 0; k < 200 && cnt < DEPTH; k++) begin
      r = (k % 2 == 0);
      if (out_valid) begin
        chk("sw_idx", 32'(out_idx), 32'(cnt));
        chk("sw_vec", 32'(out_vec), 32'(m_tbl[cnt]));
        chk("sw_last", 32'(out_last), 32'(cnt == DEPTH - 1));
        if (r) cnt++;
      end
      out_ready = r;
      step();
    end
    out_ready = 1'b1;
    chk("sw_count", 32'(cnt), 32'(DEPTH));
    chk("sw_done_busy", 32'(busy), 32'd0);
    step();
    chk("sw_no_extra", 32'(out_valid), 32'd0);

    // cfg_start, sweep_start and in_valid together: load wins
    cfg_start   = 1'b1;
    cfg_pos     = 1'($urandom);
    m_pos       = cfg_pos;
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = 4'h7;
    #1;
    chk("tri_in_ready", 32'(in_ready), 32'd0);
    step();
    cfg_start   = 1'b0;
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    m_wp        = 0;
    chk("tri_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("tri_no_result", 32'(out_valid), 32'd0);
    feed_rows(2, DEPTH);
    chk("tri_no_result2", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) lookup(4'($urandom));

    // Asynchronous reset after 7 rows, with a result pending in the slot
    lookup(4'h9);
    out_ready = 1'b0;
    start_load(1'b0);
    feed_rows(2, 7);
    chk("mid_pending", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_vec", 32'(out_vec), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    lookup(4'h2);
    chk("arst_lk2", 32'(out_vec), 32'h000);
    for (int i = 0; i < 6; i++) lookup(4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
